// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: command-side controller for block-to-block word copies.
// It emits the 2-bit {blk, we} memory command code plus a qualifier and an address.
// For each word it reads the source block, hands the data to the serializer after
// RD_LAT cycles, then writes the word taken from the deserializer into the
// destination block.
// All outputs are registered.
// Optional build macro MEM_SEQ_ABORT_EN adds the abort input and the aborted status output.
module mem_access_sequencer #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              src_blk,
  input  logic              dst_blk,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [1:0]        memoryena,
  output logic              mem_en,
  output logic [ADDR_W-1:0] addr,
  input  logic              ser_ready,
  output logic              ser_load,
  input  logic              des_valid,
  output logic              des_ack
`ifdef MEM_SEQ_ABORT_EN
  ,
  input  logic              abort,
  output logic              aborted
`endif
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_WAIT = 3'd2;
  localparam logic [2:0] WR_WAIT = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

  logic [2:0]        state_q, state_d;
  logic              src_q, src_d;
  logic              dst_q, dst_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [2:0]        lat_q, lat_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        memoryena_q, memoryena_d;
  logic              mem_en_q, mem_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ser_load_q, ser_load_d;
  logic              des_ack_q, des_ack_d;
`ifdef MEM_SEQ_ABORT_EN
  logic              aborted_q, aborted_d;
`endif

  // One bit wider than idx so the last-word compare cannot overflow at full length.
  logic [LEN_W:0]    idx_inc;
  logic [ADDR_W-1:0] word_addr;

  assign idx_inc   = {1'b0, idx_q} + {{LEN_W{1'b0}}, 1'b1};
  // Modulo 2^ADDR_W: wraps from all-ones back to zero.
  assign word_addr = base_q + ADDR_W'(idx_q);

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    base_d      = base_q;
    len_d       = len_q;
    idx_d       = idx_q;
    lat_d       = lat_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    memoryena_d = memoryena_q;
    mem_en_d    = 1'b0;
    addr_d      = addr_q;
    ser_load_d  = 1'b0;
    des_ack_d   = 1'b0;
`ifdef MEM_SEQ_ABORT_EN
    aborted_d   = aborted_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src_blk;
          dst_d   = dst_blk;
          base_d  = base_addr;
          len_d   = length;
          idx_d   = '0;
          busy_d  = 1'b1;
`ifdef MEM_SEQ_ABORT_EN
          aborted_d = 1'b0;
`endif
          state_d = (length != '0) ? RD_REQ : DONE;
        end
      end
      RD_REQ: begin
        // Hold off while the previous write is on the bus so mem_en never stays high.
        if (ser_ready && !mem_en_q) begin
          memoryena_d = {src_q, 1'b0};
          mem_en_d    = 1'b1;
          addr_d      = word_addr;
          lat_d       = LAT_INIT;
          state_d     = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (lat_q <= 3'd1) begin
          ser_load_d = 1'b1;
          state_d    = WR_WAIT;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      WR_WAIT: begin
        // des_valid is sampled at the end of the ser_load cycle at the earliest,
        // so the write always lands after the serializer capture.
        if (des_valid) begin
          memoryena_d = {dst_q, 1'b1};
          mem_en_d    = 1'b1;
          addr_d      = word_addr;
          des_ack_d   = 1'b1;
          idx_d       = idx_inc[LEN_W-1:0];
          state_d     = (idx_inc == {1'b0, len_q}) ? DONE : RD_REQ;
        end
      end
      DONE: begin
        // An abort already raised done on entry; do not pulse it twice.
        done_d  = ~done_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef MEM_SEQ_ABORT_EN
    // Access decided this cycle still goes out; only the sequencing is cut short.
    if (abort && (state_q == RD_REQ || state_q == RD_WAIT || state_q == WR_WAIT)) begin
      state_d   = DONE;
      done_d    = 1'b1;
      busy_d    = 1'b0;
      aborted_d = 1'b1;
    end
`endif
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      src_q       <= 1'b0;
      dst_q       <= 1'b0;
      base_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      lat_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      memoryena_q <= 2'b00;
      mem_en_q    <= 1'b0;
      addr_q      <= '0;
      ser_load_q  <= 1'b0;
      des_ack_q   <= 1'b0;
`ifdef MEM_SEQ_ABORT_EN
      aborted_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      base_q      <= base_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      lat_q       <= lat_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      memoryena_q <= memoryena_d;
      mem_en_q    <= mem_en_d;
      addr_q      <= addr_d;
      ser_load_q  <= ser_load_d;
      des_ack_q   <= des_ack_d;
`ifdef MEM_SEQ_ABORT_EN
      aborted_q   <= aborted_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign memoryena = memoryena_q;
  assign mem_en    = mem_en_q;
  assign addr      = addr_q;
  assign ser_load  = ser_load_q;
  assign des_ack   = des_ack_q;
`ifdef MEM_SEQ_ABORT_EN
  assign aborted   = aborted_q;
`endif

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Command-side controller that generates the 2-bit memory command code {block, write} consumed by the memory command decoder. The decoder turns that code into block1/block2 enable and write-enable strobes and serializer/deserializer enables.
- Performs block-to-block word transfers:
  - reads LENGTH words from a source block into the serializer;
  - writes the same number of words from the deserializer into a destination block.
- Handshakes with the serializer (ready/load) and deserializer (valid/ack) so no word is dropped.

Parameters:
- ADDR_W, 8, word address width of each memory block.
- LEN_W, 8, transfer length counter width.
- RD_LAT, 2, block read latency in cycles, from the enable cycle to data valid at the serializer input (legal range 1..7).

Ports:
- clk, input, 1, system clock; all state changes on rising edge.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, command strobe; sampled only in IDLE.
- src_blk, input, 1, source block: 0 = block1, 1 = block2.
- dst_blk, input, 1, destination block, same encoding.
- base_addr, input, ADDR_W, first word address; used for both source and destination.
- length, input, LEN_W, number of words to transfer.
- busy, output, 1, high from the cycle after an accepted start until done.
- done, output, 1, one-cycle completion pulse.
- memoryena, output, 2, command code {blk, we}:
  - 00 = read block1
  - 01 = write block1
  - 10 = read block2
  - 11 = write block2
- mem_en, output, 1, qualifies memoryena; the decoder output is ignored downstream when low.
- addr, output, ADDR_W, word address for the current access.
- ser_ready, input, 1, serializer can accept a word.
- ser_load, output, 1, one-cycle pulse: read data valid, serializer must capture it.
- des_valid, input, 1, deserializer holds a complete word.
- des_ack, output, 1, one-cycle pulse: word consumed.

Behaviour:
- All outputs are registered (Moore).
- Reset values: busy=0, done=0, memoryena=00, mem_en=0, addr=0, ser_load=0, des_ack=0, state=IDLE, idx=0.
- Reset asserted mid-transfer aborts immediately to the reset values. No partial-state recovery is provided.

State machine:
- IDLE
  - start=1 with length≠0: latch src_blk, dst_blk, base_addr, length; idx=0; go RD_REQ.
  - start=1 with length=0: go DONE; no memory access occurs.
  - start=0: remain in IDLE.
- RD_REQ
  - Wait for ser_ready=1.
  - When ser_ready=1: drive memoryena={src,0}, mem_en=1, addr=base+idx for exactly one cycle; load latency counter=RD_LAT; go RD_WAIT.
- RD_WAIT
  - mem_en=0; decrement the latency counter.
  - When the count expires, pulse ser_load for one cycle, then go WR_WAIT.
  - Total latency from mem_en to ser_load is RD_LAT cycles.
- WR_WAIT
  - Wait for des_valid=1.
  - When des_valid=1: drive memoryena={dst,1}, mem_en=1, addr=base+idx, des_ack=1, all in the same single cycle.
  - Then idx=idx+1. If idx+1==length go DONE, else go RD_REQ.
- DONE
  - done=1 for one cycle, busy=0, mem_en=0; return to IDLE.

Rules:
- start while busy is ignored; latched parameters never change mid-transfer.
- Address arithmetic is modulo 2^ADDR_W; base+idx wraps from all-ones to 0 silently.
- length=2^LEN_W-1 must complete with no counter overflow; idx is LEN_W bits wide.
- src_blk==dst_blk is legal (in-place copy); the read precedes the write for each index.
- mem_en is never high in two consecutive cycles; read and write never overlap.
- If des_valid is already high in the cycle ser_load pulses, the write is issued in the next cycle, not the same cycle.

Optional Feature:
- Macro: MEM_SEQ_ABORT_EN.
- When defined:
  - Adds input abort (1 bit) and output aborted (1 bit, reset 0).
  - abort=1 in any non-IDLE, non-DONE state forces DONE on the next edge; any access driven in that cycle still completes.
  - done pulses with aborted=1; aborted clears when the next start is accepted.
  - abort in IDLE or DONE has no effect.
- When undefined: neither port exists and the transfer always runs to length.

Test Plan:
- Basic copy:
  - Stimulus: src=0, dst=1, base=0x10, length=3, ser_ready and des_valid tied high, RD_LAT=2.
  - Required: reads at 0x10/0x11/0x12 with code 00, writes at the same addresses with code 11, ser_load exactly 2 cycles after each read, done one cycle after the third write, busy low afterwards.
- Zero length:
  - Stimulus: start with length=0.
  - Required: done pulses 2 cycles after start, mem_en never asserts.
- Backpressure:
  - Stimulus: hold ser_ready low 5 cycles, then des_valid low 4 cycles after ser_load.
  - Required: no mem_en during the stalls, and exactly one read and one write per word.
- Wrap:
  - Stimulus: base=0xFE, length=4.
  - Required: addresses 0xFE, 0xFF, 0x00, 0x01.
- Reset and start handling:
  - Stimulus: assert rst during RD_WAIT of word 2, then start again during busy.
  - Required: all outputs return to reset values immediately on rst; the restart command runs cleanly; a start issued while busy is ignored.
- Abort (MEM_SEQ_ABORT_EN defined):
  - Stimulus: abort during WR_WAIT of word 1 with length=5.
  - Required: done=1 and aborted=1 on the next cycle, and only one write was issued.
